spi_byte_rx: RTL and testbench

- Upstream front end of the LED controller.
- Receives the host SPI stream (mode 0, MSB first) plus the D/C sideband pin, all asynchronous to the system clock.
- Presents each completed byte as a single-cycle strobe with data and D/C flag to the layer write controller.
- Also exports the synchronized, glitch-free CS level that the layer write controller edge-detects for frame restart.

---
 rtl/cube0414_pkg.sv | 15 +
 rtl/edge2en.sv | 19 +
 rtl/sync_ff.sv | 22 ++
 rtl/spi_byte_rx.sv | 119 +++++++++++
 tb/tb_spi_byte_rx.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cube0414_pkg.sv
// Shared types and protocol constants for the cube0414 LED controller.
// Byte type, receiver FSM encoding and host command codes.
package cube0414_pkg;

  localparam logic [7:0] CUBE0414_ADDR_WR = 8'hcc;
  localparam logic [7:0] CUBE0414_DATA_WR = 8'hda;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/edge2en.sv
// Rising-edge to one-cycle enable converter for a synchronous level.
// Ports: clk_in, rst_n_in, sig_in -> en_out (high on 0->1 cycle).
module edge2en (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic sig_in,
  output logic en_out
);

  logic r_prev;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_prev <= 1'b0;
    else           r_prev <= sig_in;
  end

  assign en_out = sig_in & ~r_prev;

endmodule

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with a selectable reset value.
// Ports: clk_in, rst_n_in, d_in (async) -> q_out (synced).
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d_in,
  output logic q_out
);

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_sync <= {DEPTH{RST_VAL}};
    else           r_sync <= {r_sync[DEPTH-2:0], d_in};
  end

  assign q_out = r_sync[DEPTH-1];

endmodule

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver with D/C sideband for the LED controller.
// Ports: async SPI pads + dc_in in; synced CS, byte strobe/data/dc out.
module spi_byte_rx
  import cube0414_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic  clk_in,
  input  logic  rst_n_in,
  input  logic  spi_sclk_in,
  input  logic  spi_mosi_in,
  input  logic  spi_cs_n_in,
  input  logic  dc_in,
  output logic  spi_cs_n_out,
  output logic  byte_rdy_out,
  output byte_t byte_data_out,
  output logic  dc_out
);

  logic w_sclk_s;
  logic w_mosi_s;
  logic w_cs_n_s;
  logic w_dc_s;
  logic w_sclk_r;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .d_in(spi_sclk_in), .q_out(w_sclk_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .d_in(spi_mosi_in), .q_out(w_mosi_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .d_in(spi_cs_n_in), .q_out(w_cs_n_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .d_in(dc_in), .q_out(w_dc_s)
  );

  edge2en u_sclk_edge (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .sig_in(w_sclk_s), .en_out(w_sclk_r)
  );

  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  byte_t      r_shift;
  byte_t      w_shift_nxt;
  byte_t      r_data;
  logic [2:0] r_cnt;
  logic       r_rdy;
  logic       r_dc;
  logic       w_shift_en;
  logic       w_done;
  logic       w_clr;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (!w_cs_n_s) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_cs_n_s)  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // The state still reads SHIFT on the cycle CS is first seen high,
  // so a final edge landing with the CS rise still completes its byte.
  always_comb begin
    w_shift_en = (r_state == ST_SHIFT) && w_sclk_r;
    w_done     = w_shift_en && (r_cnt == 3'd7);
    w_clr      = (r_state == ST_IDLE) || (w_cs_n_s && !w_sclk_r);
    if (MSB_FIRST) w_shift_nxt = {r_shift[6:0], w_mosi_s};
    else           w_shift_nxt = {w_mosi_s, r_shift[7:1]};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_shift_en) begin
      r_shift <= w_shift_nxt;
      r_cnt   <= r_cnt + 3'd1;
    end else if (w_clr) begin
      r_cnt   <= '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rdy  <= 1'b0;
      r_data <= '0;
      r_dc   <= 1'b0;
    end else begin
      r_rdy <= w_done;
      if (w_done) begin
        r_data <= w_shift_nxt;
        r_dc   <= w_dc_s;
      end
    end
  end

  assign spi_cs_n_out  = w_cs_n_s;
  assign byte_rdy_out  = r_rdy;
  assign byte_data_out = r_data;
  assign dc_out        = r_dc;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Self-checking bench for spi_byte_rx: vector table plus corner cases.
// Strobes are matched against a queue filled when the 8th edge is driven.
module tb_spi_byte_rx;
  import cube0414_pkg::*;

  localparam int SS   = 2;
  localparam int HALF = 4;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  sclk = 1'b0;
  logic  mosi = 1'b0;
  logic  cs_n = 1'b1;
  logic  dc = 1'b0;
  logic  cs_n_o;
  logic  rdy_o;
  byte_t data_o;
  logic  dc_o;

  spi_byte_rx #(.SYNC_STAGES(SS), .MSB_FIRST(1'b1)) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .spi_sclk_in(sclk),
    .spi_mosi_in(mosi),
    .spi_cs_n_in(cs_n),
    .dc_in(dc),
    .spi_cs_n_out(cs_n_o),
    .byte_rdy_out(rdy_o),
    .byte_data_out(data_o),
    .dc_out(dc_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int fails = 0;
  int strobes = 0;
  int pushed = 0;

  typedef struct {
    byte_t data;
    logic  dc;
    int    t;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    byte_t in_data;
    logic  in_dc;
    int    in_bits;
    bit    hold_cs;
    bit    exp_stb;
    byte_t exp_data;
    logic  exp_dc;
  } vec_t;

  vec_t vecs[6];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, act, req);
    end
  endtask

  logic prev_rdy = 1'b0;

  always @(negedge clk) begin
    if (rdy_o === 1'b1) begin
      exp_t e;
      int   lat;
      strobes++;
      check("no_back_to_back", {31'd0, prev_rdy}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_strobe got=%0h want=none", data_o);
      end else begin
        e = sb.pop_front();
        check("strobe_data", {24'd0, data_o}, {24'd0, e.data});
        check("strobe_dc", {31'd0, dc_o}, {31'd0, e.dc});
        lat = cyc - e.t;
        checks++;
        if (lat < SS + 1 || lat > SS + 2) begin
          fails++;
          $display("FAIL strobe_latency got=%0d want=%0d..%0d",
                   lat, SS + 1, SS + 2);
        end
      end
    end
    prev_rdy = rdy_o;
  end

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic send_frame(byte_t d, logic dcv, int nbits, bit hold,
                            bit ex, byte_t ed, logic edc, bit cs_on_edge);
    dc = dcv;
    if (cs_n) begin
      cs_n = 1'b0;
      wait_clk(HALF);
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7-i];
      wait_clk(HALF);
      sclk = 1'b1;
      if (i == 7 && cs_on_edge) cs_n = 1'b1;
      if (i == 7 && ex) begin
        sb.push_back('{ed, edc, cyc});
        pushed++;
      end
      wait_clk(HALF);
      sclk = 1'b0;
    end
    if (!hold) begin
      wait_clk(HALF);
      cs_n = 1'b1;
    end
    wait_clk(HALF);
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_rdy"}, {31'd0, rdy_o}, 32'd0);
    check({tag, "_data"}, {24'd0, data_o}, 32'd0);
    check({tag, "_dc"}, {31'd0, dc_o}, 32'd0);
    check({tag, "_cs"}, {31'd0, cs_n_o}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{CUBE0414_ADDR_WR, 1'b0, 8, 1'b0, 1'b1,
                CUBE0414_ADDR_WR, 1'b0};
    vecs[1] = '{8'h12, 1'b1, 8, 1'b1, 1'b1, 8'h12, 1'b1};
    vecs[2] = '{8'h34, 1'b1, 8, 1'b1, 1'b1, 8'h34, 1'b1};
    vecs[3] = '{8'h56, 1'b1, 8, 1'b0, 1'b1, 8'h56, 1'b1};
    vecs[4] = '{8'hff, 1'b0, 5, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{CUBE0414_DATA_WR, 1'b0, 8, 1'b0, 1'b1,
                CUBE0414_DATA_WR, 1'b0};

    wait_clk(3);
    check_reset_outs("reset");
    rst_n = 1'b1;
    wait_clk(100);
    check_reset_outs("idle");

    for (int k = 0; k < 6; k++) begin
      send_frame(vecs[k].in_data, vecs[k].in_dc, vecs[k].in_bits,
                 vecs[k].hold_cs, vecs[k].exp_stb,
                 vecs[k].exp_data, vecs[k].exp_dc, 1'b0);
      if (vecs[k].exp_stb) begin
        check("hold_data", {24'd0, data_o}, {24'd0, vecs[k].exp_data});
        check("hold_dc", {31'd0, dc_o}, {31'd0, vecs[k].exp_dc});
      end
    end
    wait_clk(10);

    cs_n = 1'b0;
    wait_clk(SS + 1);
    check("cs_sync_low", {31'd0, cs_n_o}, 32'd0);
    send_frame(8'ha5, 1'b1, 8, 1'b1, 1'b1, 8'ha5, 1'b1, 1'b1);
    wait_clk(SS + 1);
    check("cs_sync_high", {31'd0, cs_n_o}, 32'd1);
    check("cs_edge_data", {24'd0, data_o}, 32'ha5);

    send_frame(8'h3c, 1'b0, 4, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_reset_outs("midbyte_rst");
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    check_reset_outs("post_rst");
    send_frame(8'h3c, 1'b1, 8, 1'b0, 1'b1, 8'h3c, 1'b1, 1'b0);
    check("after_rst_data", {24'd0, data_o}, 32'h3c);

    wait_clk(20);
    check("sb_drained", sb.size(), 32'd0);
    check("strobe_count", strobes, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
